// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, mux selects
// and the one-hot instruction class produced by the opcode decoder.
package mc_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IARITH = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b10;

  localparam logic [SEL_W-1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [SEL_W-1:0] ALU_OP_FUNCT  = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OP_BRANCH = 2'b10;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MDR = 1'b1;

  // One-hot instruction class; all-zero means unknown opcode.
  typedef struct packed {
    logic r_type;
    logic i_arith;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic system;
  } inst_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Maps the 7-bit opcode to a one-hot instruction class.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output inst_class_t         inst_class
);

  always_comb begin
    inst_class = '0;
    case (opcode)
      OP_RTYPE:  inst_class.r_type  = 1'b1;
      OP_IARITH: inst_class.i_arith = 1'b1;
      OP_LOAD:   inst_class.load    = 1'b1;
      OP_STORE:  inst_class.store   = 1'b1;
      OP_BRANCH: inst_class.branch  = 1'b1;
      OP_JAL:    inst_class.jal     = 1'b1;
      OP_JALR:   inst_class.jalr    = 1'b1;
      OP_SYSTEM: inst_class.system  = 1'b1;
      default:   inst_class = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32 control FSM. Outputs are Mealy (IF/MEM strobes follow mem_ready)
// and are forced to zero while reset_n is low, without waiting for a clock edge.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                is_ecall_halt,
  input  logic                alu_bcond,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                mdr_write,
  output logic                alu_out_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [SEL_W-1:0]    alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op_sel,
  output logic                wb_sel,
  output logic                is_halted
);

  state_t      state, state_nxt;
  inst_class_t cls;

  mc_opcode_decode u_decode (
    .opcode     (opcode),
    .inst_class (cls)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IF;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    alu_out_write = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op_sel    = ALU_OP_ADD;
    wb_sel        = WB_SEL_ALU;
    is_halted     = 1'b0;

    if (reset_n) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            state_nxt = S_ID;
          end
        end

        // PC <= PC+4 and ALUOut <= PC+4 for every instruction.
        S_ID: begin
          alu_src_a     = SRC_A_PC;
          alu_src_b     = SRC_B_FOUR;
          alu_out_write = 1'b1;
          pc_write      = 1'b1;
          if (cls.system && is_ecall_halt)  state_nxt = S_HALT;
          else if (cls.system || cls == '0) state_nxt = S_IF;
          else                              state_nxt = S_EX;
        end

        S_EX: begin
          state_nxt = S_IF;
          if (cls.r_type) begin
            alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_RS2; alu_op_sel = ALU_OP_FUNCT;
            alu_out_write = 1'b1;  state_nxt = S_WB;
          end else if (cls.i_arith) begin
            alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_IMM; alu_op_sel = ALU_OP_FUNCT;
            alu_out_write = 1'b1;  state_nxt = S_WB;
          end else if (cls.load || cls.store) begin
            alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_IMM;
            alu_out_write = 1'b1;  state_nxt = S_MEM;
          end else if (cls.branch) begin
            alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_RS2; alu_op_sel = ALU_OP_BRANCH;
            state_nxt = alu_bcond ? S_BR : S_IF;
          end else if (cls.jal) begin
            // ALUOut keeps PC+4 from ID as the link value.
            alu_src_a = SRC_A_OLD_PC; alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;         state_nxt = S_WB;
          end else if (cls.jalr) begin
            alu_src_a = SRC_A_RS1; alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;      state_nxt = S_WB;
          end
        end

        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = cls.load;
          mem_write = cls.store;
          if (mem_ready) begin
            mdr_write = cls.load;
            state_nxt = cls.load ? S_WB : S_IF;
          end
        end

        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = cls.load ? WB_SEL_MDR : WB_SEL_ALU;
          state_nxt = S_IF;
        end

        S_BR: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          pc_write  = 1'b1;
          state_nxt = S_IF;
        end

        S_HALT: begin
          is_halted = 1'b1;
          state_nxt = S_HALT;
        end

        default: state_nxt = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed-vector bench for mc_control_unit: checks every output, every cycle.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       is_ecall_halt, alu_bcond, mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, mdr_write;
  logic       alu_out_write, pc_write, reg_write, wb_sel, is_halted;
  logic [1:0] alu_src_a, alu_src_b, alu_op_sel;
  logic [15:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .is_ecall_halt(is_ecall_halt),
    .alu_bcond(alu_bcond), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write), .mdr_write(mdr_write),
    .alu_out_write(alu_out_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .wb_sel(wb_sel), .is_halted(is_halted)
  );

  assign obs = {mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_out_write,
                pc_write, reg_write, alu_src_a, alu_src_b, alu_op_sel, wb_sel, is_halted};

  // Expected output vector in the same bit order as obs.
  function automatic logic [15:0] ev(input logic mr, input logic mw, input logic iod,
                                     input logic irw, input logic mdrw, input logic aow,
                                     input logic pcw, input logic rw, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] op,
                                     input logic wbs, input logic h);
    return {mr, mw, iod, irw, mdrw, aow, pcw, rw, sa, sb, op, wbs, h};
  endfunction

  task automatic chk(input string tag, input logic [15:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Drive inputs for one cycle, check outputs at the falling edge, advance.
  task automatic step(input string tag, input logic rdy, input logic bc, input logic eh,
                      input logic [15:0] e);
    mem_ready = rdy; alu_bcond = bc; is_ecall_halt = eh;
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] e_zero, e_if_wait, e_if_done, e_id, e_ex_r, e_ex_i, e_ex_ls, e_ex_br;
  logic [15:0] e_br, e_ex_jal, e_ex_jalr, e_wb_alu, e_wb_mdr, e_halt;
  logic [15:0] e_mem_ld_wait, e_mem_ld_done, e_mem_st_wait, e_mem_st_done;

  initial begin
    e_zero        = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_if_wait     = ev(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_if_done     = ev(1,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_id          = ev(0,0,0,0,0,1,1,0,2'b00,2'b01,2'b00,0,0);
    e_ex_r        = ev(0,0,0,0,0,1,0,0,2'b10,2'b00,2'b01,0,0);
    e_ex_i        = ev(0,0,0,0,0,1,0,0,2'b10,2'b10,2'b01,0,0);
    e_ex_ls       = ev(0,0,0,0,0,1,0,0,2'b10,2'b10,2'b00,0,0);
    e_ex_br       = ev(0,0,0,0,0,0,0,0,2'b10,2'b00,2'b10,0,0);
    e_br          = ev(0,0,0,0,0,0,1,0,2'b01,2'b10,2'b00,0,0);
    e_ex_jal      = ev(0,0,0,0,0,0,1,0,2'b01,2'b10,2'b00,0,0);
    e_ex_jalr     = ev(0,0,0,0,0,0,1,0,2'b10,2'b10,2'b00,0,0);
    e_wb_alu      = ev(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0,0);
    e_wb_mdr      = ev(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,1,0);
    e_halt        = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);
    e_mem_ld_wait = ev(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_mem_ld_done = ev(1,0,1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_mem_st_wait = ev(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_mem_st_done = ev(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);

    reset_n = 1'b0; opcode = 7'b0110011;
    mem_ready = 1'b1; alu_bcond = 1'b0; is_ecall_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", e_zero);
    reset_n = 1'b1;

    // ADD: IF, ID, EX, WB with mem_ready held high throughout
    opcode = 7'b0110011;
    step("add_if", 1, 0, 0, e_if_done);
    step("add_id", 1, 0, 0, e_id);
    step("add_ex", 1, 0, 0, e_ex_r);
    step("add_wb", 1, 0, 0, e_wb_alu);

    // LW: 3 wait cycles in IF, 2 in MEM
    opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) step("lw_if_wait", 0, 0, 0, e_if_wait);
    step("lw_if_done", 1, 0, 0, e_if_done);
    step("lw_id", 0, 0, 0, e_id);
    step("lw_ex", 0, 0, 0, e_ex_ls);
    for (int i = 0; i < 2; i++) step("lw_mem_wait", 0, 0, 0, e_mem_ld_wait);
    step("lw_mem_done", 1, 0, 0, e_mem_ld_done);
    step("lw_wb", 1, 0, 0, e_wb_mdr);

    // ADDI
    opcode = 7'b0010011;
    step("addi_if", 1, 0, 0, e_if_done);
    step("addi_id", 1, 0, 0, e_id);
    step("addi_ex", 1, 0, 0, e_ex_i);
    step("addi_wb", 1, 0, 0, e_wb_alu);

    // BEQ taken then not taken
    opcode = 7'b1100011;
    step("beq_t_if", 1, 0, 0, e_if_done);
    step("beq_t_id", 1, 0, 0, e_id);
    step("beq_t_ex", 1, 1, 0, e_ex_br);
    step("beq_t_br", 1, 0, 0, e_br);
    step("beq_n_if", 1, 0, 0, e_if_done);
    step("beq_n_id", 1, 0, 0, e_id);
    step("beq_n_ex", 1, 0, 0, e_ex_br);
    step("beq_n_next_if", 1, 0, 0, e_if_done);
    step("beq_n_next_id", 1, 0, 0, e_id);
    opcode = 7'b1101111;
    step("jal_ex", 1, 0, 0, e_ex_jal);
    step("jal_wb", 1, 0, 0, e_wb_alu);

    // JALR
    opcode = 7'b1100111;
    step("jalr_if", 1, 0, 0, e_if_done);
    step("jalr_id", 1, 0, 0, e_id);
    step("jalr_ex", 1, 0, 0, e_ex_jalr);
    step("jalr_wb", 1, 0, 0, e_wb_alu);

    // is_ecall_halt on a non-system opcode has no effect; unknown opcode returns to IF
    opcode = 7'b0110011;
    step("flag_nonsys_if", 1, 0, 1, e_if_done);
    step("flag_nonsys_id", 1, 0, 1, e_id);
    step("flag_nonsys_ex", 1, 0, 0, e_ex_r);
    step("flag_nonsys_wb", 1, 0, 0, e_wb_alu);
    opcode = 7'b0110111;
    step("unk_if", 1, 0, 0, e_if_done);
    step("unk_id", 1, 0, 0, e_id);
    step("unk_next_if", 0, 0, 0, e_if_wait);

    // ecall without halt flag returns to IF
    opcode = 7'b1110011;
    step("ecall_if", 1, 0, 0, e_if_done);
    step("ecall_id", 1, 0, 0, e_id);
    step("ecall_next_if", 1, 0, 0, e_if_done);
    step("halt_id", 1, 0, 1, e_id);
    for (int i = 0; i < 20; i++) step("halt_hold", 1, 1, 1, e_halt);

    // SW with reset pulsed during the memory wait
    reset_n = 1'b0;
    #2;
    chk("reset_from_halt", e_zero);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    opcode = 7'b0100011;
    step("sw_if", 1, 0, 0, e_if_done);
    step("sw_id", 0, 0, 0, e_id);
    step("sw_ex", 0, 0, 0, e_ex_ls);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_mem_wait", e_mem_st_wait);
    #2;
    reset_n = 1'b0;
    #1;
    chk("sw_reset_async", e_zero);
    @(posedge clk);
    #1;
    chk("sw_reset_held", e_zero);
    reset_n = 1'b1;
    step("sw_restart_if", 0, 0, 0, e_if_wait);
    step("sw2_if", 1, 0, 0, e_if_done);
    step("sw2_id", 1, 0, 0, e_id);
    step("sw2_ex", 1, 0, 0, e_ex_ls);
    step("sw2_mem_done", 1, 0, 0, e_mem_st_done);
    step("sw2_next_if", 1, 0, 0, e_if_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
